// File: rtl/riscv_pkg.sv
// Shared load/store definitions: funct3 access-size codes, FSM states and
// the size-to-byte-count decode used by the data memory unit.
package riscv_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD1,
    ST_LD2,
    ST_ST2
  } state_t;

  function automatic logic [2:0] sizeBytes(input logic [2:0] size);
    case (size[1:0])
      2'b00:   sizeBytes = 3'd1;
      2'b01:   sizeBytes = 3'd2;
      default: sizeBytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load result formatter: shifts the {hi,lo} word pair down by the byte offset,
// keeps the accessed bytes and sign- or zero-extends them to 32 bits.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_size,
  output logic [31:0] o_data
);

  logic [31:0] w_window;

  assign w_window = 32'({i_hi, i_lo} >> {i_off, 3'b000});

  always_comb begin
    o_data = '0;
    case (i_size)
      SZ_B:    o_data = {{24{w_window[7]}}, w_window[7:0]};
      SZ_H:    o_data = {{16{w_window[15]}}, w_window[15:0]};
      SZ_W:    o_data = w_window;
      SZ_BU:   o_data = {24'h0, w_window[7:0]};
      SZ_HU:   o_data = {16'h0, w_window[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Load/store responder on a word-wide single-port SRAM; steers byte lanes,
// extends load data and splits accesses that straddle a word boundary.
module data_mem_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              ready,
  input  logic              data_read_en,
  input  logic              data_write_en,
  input  logic [2:0]        data_size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            r_state, w_nextState;
  logic              w_accept, w_illegal, w_split, w_unused;
  logic [1:0]        w_off;
  logic [2:0]        w_nbytes;
  logic [3:0]        w_beMask;
  logic [7:0]        w_beWin;
  logic [31:0]       w_wdMasked;
  logic [63:0]       w_wdWin;
  logic [ADDR_W-1:0] w_wordAddr;
  logic [31:0]       w_alignLo, w_alignData;

  logic [1:0]        r_off;
  logic [2:0]        r_size;
  logic              r_split;
  logic [ADDR_W-1:0] r_addr2;
  logic [31:0]       r_hiData, r_lo;
  logic [3:0]        r_hiBe;
  logic              r_rspValid, r_rspErr;
  logic [31:0]       r_rspRdata;

  assign ready      = (r_state == ST_IDLE);
  assign w_accept   = req_valid && ready && (data_read_en || data_write_en);
  assign w_off      = addr[1:0];
  assign w_nbytes   = sizeBytes(data_size);
  assign w_split    = ({1'b0, w_off} + w_nbytes) > 3'd4;
  assign w_wordAddr = addr[ADDR_W+1:2];
  assign w_unused   = &{1'b0, addr[31:ADDR_W+2]};

  always_comb begin
    w_illegal = 1'b0;
    if (data_read_en && data_write_en)
      w_illegal = 1'b1;
    else if (data_read_en)
      w_illegal = !(data_size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU});
    else if (data_write_en)
      w_illegal = !(data_size inside {SZ_B, SZ_H, SZ_W});
  end

  // Store data and byte enables live in a 64-bit window: low half is the first word, high half the second.
  always_comb begin
    w_wdMasked = wdata;
    w_beMask   = 4'b1111;
    case (w_nbytes)
      3'd1: begin w_wdMasked = {24'h0, wdata[7:0]};  w_beMask = 4'b0001; end
      3'd2: begin w_wdMasked = {16'h0, wdata[15:0]}; w_beMask = 4'b0011; end
      default: ;
    endcase
  end

  assign w_wdWin = {32'h0, w_wdMasked} << {w_off, 3'b000};
  assign w_beWin = {4'b0000, w_beMask} << w_off;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_be      = 4'b0000;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_illegal) begin
          mem_en    = 1'b1;
          mem_we    = data_write_en;
          mem_addr  = w_wordAddr;
          mem_be    = data_write_en ? w_beWin[3:0] : 4'b1111;
          mem_wdata = data_write_en ? w_wdWin[31:0] : 32'h0;
          if (data_read_en) w_nextState = ST_LD1;
          else if (w_split) w_nextState = ST_ST2;
        end
      end
      ST_LD1: begin
        if (r_split) begin
          mem_en      = 1'b1;
          mem_addr    = r_addr2;
          mem_be      = 4'b1111;
          w_nextState = ST_LD2;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_LD2: w_nextState = ST_IDLE;
      ST_ST2: begin
        mem_en      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = r_addr2;
        mem_be      = r_hiBe;
        mem_wdata   = r_hiData;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
    if (!rst_n) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_off    <= w_off;
      r_size   <= data_size;
      r_split  <= w_split;
      r_addr2  <= w_wordAddr + ADDR_W'(1);
      r_hiData <= w_wdWin[63:32];
      r_hiBe   <= w_beWin[7:4];
    end
    if (r_state == ST_LD1) r_lo <= mem_rdata;
  end

  assign w_alignLo = (r_state == ST_LD1) ? mem_rdata : r_lo;

  load_align u_loadAlign (
    .i_hi   (mem_rdata),
    .i_lo   (w_alignLo),
    .i_off  (r_off),
    .i_size (r_size),
    .o_data (w_alignData)
  );

  // The response is registered so it lands in the cycle the FSM is back in IDLE and can accept again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      r_rspRdata <= 32'h0;
    end else begin
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (w_illegal || (data_write_en && !w_split))) begin
            r_rspValid <= 1'b1;
            r_rspErr   <= w_illegal;
            r_rspRdata <= 32'h0;
          end
        end
        ST_LD1: begin
          if (!r_split) begin
            r_rspValid <= 1'b1;
            r_rspRdata <= w_alignData;
          end
        end
        ST_LD2: begin
          r_rspValid <= 1'b1;
          r_rspRdata <= w_alignData;
        end
        ST_ST2: begin
          r_rspValid <= 1'b1;
          r_rspRdata <= 32'h0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_err   = r_rspErr;
  assign rsp_rdata = r_rspRdata;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboarded bench for data_mem_unit: byte-array reference model predicts each
// response, a negedge monitor pops and compares it, and directed steps probe the SRAM bus.
module tb_data_mem_unit;
  import riscv_pkg::*;

  localparam int ADDR_W = 10;
  localparam int NBYTES = 4 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, ready, data_read_en, data_write_en;
  logic [2:0]        data_size;
  logic [31:0]       addr, wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          dueCycle;
  } expect_t;

  expect_t     scoreboard[$];
  logic [31:0] sram [0:(1<<ADDR_W)-1];
  logic [31:0] initImage [0:(1<<ADDR_W)-1];
  logic [7:0]  refMem [0:NBYTES-1];
  logic        loadImage;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  data_mem_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .ready(ready),
    .data_read_en(data_read_en), .data_write_en(data_write_en), .data_size(data_size),
    .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: byte-enabled writes, one-cycle registered read data.
  always @(posedge clk) begin
    if (loadImage) begin
      for (int i = 0; i < (1<<ADDR_W); i++) sram[i] <= initImage[i];
    end else if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    expect_t e;
    if (rst_n && rsp_valid) begin
      compared++;
      if (scoreboard.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_rsp: got rdata=0x%08h err=%0b at cycle %0d, required no response",
                 rsp_rdata, rsp_err, cyc);
      end else begin
        e = scoreboard.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc != e.dueCycle) begin
          mismatched++;
          $display("[TB] FAIL response: got rdata=0x%08h err=%0b cycle=%0d, required rdata=0x%08h err=%0b cycle=%0d",
                   rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.dueCycle);
        end
      end
    end
  end

  function automatic int refBytes(input logic [2:0] size);
    return (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit isIllegal(input logic rd, input logic wr, input logic [2:0] size);
    if (rd && wr) return 1'b1;
    if (rd) return !(size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    return !(size inside {3'b000, 3'b001, 3'b010});
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [2:0] size);
    logic [31:0] v = 0;
    int n = refBytes(size);
    for (int i = 0; i < n; i++) v = v | (32'(refMem[(a + i) % NBYTES]) << (8*i));
    if (size == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (size == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  // Presents a request and returns at the negedge of its accept cycle, leaving it driven.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] size,
                               input logic [31:0] a, input logic [31:0] wd);
    expect_t e;
    int waited = 0;
    int n = refBytes(size);
    bit split = (int'(a[1:0]) + n) > 4;
    req_valid = 1'b1; data_read_en = rd; data_write_en = wr;
    data_size = size; addr = a; wdata = wd;
    @(negedge clk);
    while (!ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!ready) begin
      checkOutput("ready_timeout", {31'h0, ready}, 32'h1);
      return;
    end
    e.err = 1'b0;
    e.rdata = 32'h0;
    if (isIllegal(rd, wr, size)) begin
      e.err = 1'b1;
      e.dueCycle = cyc + 1;
    end else if (wr) begin
      for (int i = 0; i < n; i++) refMem[(a + i) % NBYTES] = wd[8*i +: 8];
      e.dueCycle = cyc + (split ? 2 : 1);
    end else begin
      e.rdata = refLoad(a, size);
      e.dueCycle = cyc + (split ? 3 : 2);
    end
    scoreboard.push_back(e);
  endtask

  task automatic finishReq();
    @(posedge clk);
    #1;
    req_valid = 1'b0; data_read_en = 1'b0; data_write_en = 1'b0;
  endtask

  task automatic noEnable(input logic [31:0] a);
    req_valid = 1'b1; data_read_en = 1'b0; data_write_en = 1'b0; addr = a;
    @(negedge clk);
    if (ready) checkOutput("no_enable_mem_en", {31'h0, mem_en}, 32'h0);
    finishReq();
  endtask

  initial begin
    logic [31:0] rA, rD;
    logic [2:0]  rS;
    logic        rRd, rWr;
    int          sel, drain;

    for (int i = 0; i < (1<<ADDR_W); i++) begin
      initImage[i] = $urandom;
      for (int b = 0; b < 4; b++) refMem[4*i + b] = initImage[i][8*b +: 8];
    end
    loadImage = 1'b1;
    rst_n = 1'b0;
    req_valid = 1'b1; data_read_en = 1'b0; data_write_en = 1'b1;
    data_size = SZ_W; addr = 32'h40; wdata = 32'h5555_AAAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_mem_en", {31'h0, mem_en}, 32'h0);
    checkOutput("reset_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("reset_ready", {31'h0, ready}, 32'h1);
    checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    @(posedge clk); #1;
    loadImage = 1'b0; rst_n = 1'b1; req_valid = 1'b0; data_write_en = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1'b0, 1'b1, SZ_W, 32'h10, 32'hDEADBEEF);
    checkOutput("sw_mem_addr", 32'(mem_addr), 32'd4);
    checkOutput("sw_mem_be", {28'h0, mem_be}, 32'hF);
    checkOutput("sw_mem_we", {31'h0, mem_we}, 32'h1);
    checkOutput("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    finishReq();
    applyStimulus(1'b1, 1'b0, SZ_W, 32'h10, 32'h0);   finishReq();

    applyStimulus(1'b0, 1'b1, SZ_W, 32'h10, 32'h80FF7F01); finishReq();
    applyStimulus(1'b1, 1'b0, SZ_B,  32'h13, 32'h0); finishReq();
    applyStimulus(1'b1, 1'b0, SZ_BU, 32'h13, 32'h0); finishReq();
    applyStimulus(1'b1, 1'b0, SZ_H,  32'h12, 32'h0); finishReq();
    applyStimulus(1'b1, 1'b0, SZ_HU, 32'h10, 32'h0); finishReq();

    applyStimulus(1'b0, 1'b1, SZ_W, 32'h21, 32'h11223344);
    checkOutput("split_sw_addr0", 32'(mem_addr), 32'd8);
    checkOutput("split_sw_be0", {28'h0, mem_be}, 32'hE);
    checkOutput("split_sw_wdata0", mem_wdata, 32'h22334400);
    finishReq();
    @(negedge clk);
    checkOutput("split_sw_addr1", 32'(mem_addr), 32'd9);
    checkOutput("split_sw_be1", {28'h0, mem_be}, 32'h1);
    checkOutput("split_sw_wdata1", mem_wdata, 32'h00000011);
    checkOutput("split_sw_we1", {31'h0, mem_we}, 32'h1);
    applyStimulus(1'b1, 1'b0, SZ_W, 32'h21, 32'h0); finishReq();

    applyStimulus(1'b0, 1'b1, SZ_B, 32'hFFF, 32'h000000AB); finishReq();
    applyStimulus(1'b0, 1'b1, SZ_B, 32'h000, 32'h000000CD); finishReq();
    applyStimulus(1'b1, 1'b0, SZ_H, 32'hFFF, 32'h0);
    checkOutput("wrap_addr0", 32'(mem_addr), 32'd1023);
    finishReq();
    @(negedge clk);
    checkOutput("wrap_addr1", 32'(mem_addr), 32'd0);
    checkOutput("wrap_en1", {31'h0, mem_en}, 32'h1);

    applyStimulus(1'b1, 1'b0, 3'b011, 32'h30, 32'h0);
    checkOutput("illegal_size_mem_en", {31'h0, mem_en}, 32'h0);
    finishReq();
    applyStimulus(1'b1, 1'b1, SZ_W, 32'h30, 32'h0);
    checkOutput("illegal_both_mem_en", {31'h0, mem_en}, 32'h0);
    finishReq();
    repeat (3) @(posedge clk);
    #1;

    applyStimulus(1'b1, 1'b0, SZ_W, 32'h21, 32'h0);
    finishReq();
    rst_n = 1'b0;
    scoreboard.delete();
    @(negedge clk);
    checkOutput("midreset_mem_en", {31'h0, mem_en}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("post_reset_mem_en", {31'h0, mem_en}, 32'h0);
      checkOutput("post_reset_ready", {31'h0, ready}, 32'h1);
    end
    @(posedge clk); #1;

    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 99);
      rA = $urandom;
      rD = $urandom;
      if (sel < 40) rA = (rA & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      else if (sel < 48) rA = (rA & 32'hFFFF_F000) | 32'hFF8 | 32'($urandom_range(0, 7));
      if (sel >= 95) begin
        noEnable(rA);
      end else begin
        rRd = ($urandom_range(0, 1) == 1);
        rWr = !rRd;
        if (sel >= 92) begin rRd = 1'b1; rWr = 1'b1; end
        if (sel >= 88 && sel < 92) rS = 3'($urandom_range(0, 7));
        else if (rWr) rS = 3'($urandom_range(0, 2));
        else begin
          rS = 3'($urandom_range(0, 4));
          if (rS == 3'b011) rS = SZ_BU;
          else if (rS == 3'b100) rS = SZ_HU;
        end
        applyStimulus(rRd, rWr, rS, rA, rD);
        finishReq();
      end
    end

    drain = 0;
    while (scoreboard.size() != 0 && drain < 50) begin
      drain++;
      @(negedge clk);
    end
    if (scoreboard.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, required 0", scoreboard.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
